// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, default width, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_adder_pkg;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit counter must hold the value WIDTH without wrapping.
  function automatic int unsigned sa_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used by the serial datapath.
// Latency: purely combinational.
// Backpressure: none.
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sum = a + b + cin, one bit per clock through a single full-adder cell.
// Latency: WIDTH cycles from the start-accepting edge to the edge that raises done.
// Backpressure: start is ignored while busy; accepted again in the done cycle (no bubble).
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned   CW       = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;
  logic accept;
  logic last_bit;

  // A new operation may start from IDLE or directly out of DONE.
  assign accept   = start && (state_q != ST_RUN);
  assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST_BIT);

  Full_Adder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE lasts one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next-state: load on accept, one bit per RUN cycle, publish on the last bit.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_co;
      cnt_d   = cnt_q + CW'(1);
      // The final bit is folded straight into sum so partial results never show.
      if (last_bit) begin
        sum_d  = {fa_s, res_q[WIDTH-1:1]};
        cout_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
        // carry_q here is the carry into the MSB cell.
        ovf_d  = carry_q ^ fa_co;
`endif
      end
    end
  end

  // Datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with an expected-result queue.
// Latency: checks WIDTH-cycle completion and one-cycle done.
// Backpressure: exercises ignored start in RUN and back-to-back start in DONE.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int           tests = 0;
  int           fails = 0;
  res_t         sb[$];
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer add; overflow from carry into MSB xor carry out.
  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    res_t         r;
    logic [W:0]   t;
    logic         c_into_msb;
    t = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    c_into_msb = t[W-1] ^ ta[W-1] ^ tb_[W-1];
    r.ovf  = c_into_msb ^ t[W];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge: drive operands with start high and queue the expected result.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    a     = ta;
    b     = tb_;
    cin   = tc;
    start = 1'b1;
    sb.push_back(model(ta, tb_, tc));
  endtask

  // Drops start, waits for done (bounded), checks latency/busy/hold and pops the expected result.
  // rp_k: RUN cycle in which start is re-pulsed with a different a (0 = never).
  task automatic wait_done(input string tag, input int rp_k);
    int   k;
    int   busy_n;
    bit   hold_ok;
    res_t e;
    k = 1;
    busy_n = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && k <= 4 * W) begin
      if (busy === 1'b1) busy_n++;
      if (sum !== last_sum || cout !== last_cout) hold_ok = 1'b0;
      if (k == rp_k) begin
        start = 1'b1;
        a     = 'h11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 32'(k - 1), 32'(W));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, ".sum_held"}, 32'(hold_ok), 32'd1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".sum"}, 32'(sum), 32'(e.sum));
      check({tag, ".cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      last_sum  = e.sum;
      last_cout = e.cout;
    end
  endtask

  // One cycle after done with no new start: done gone, back in IDLE.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    res_t         dummy;
    bit           no_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset.ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    launch('h00, 'h00, 1'b0);
    wait_done("zero", 0);
    idle_check("zero");

    launch('hFF, 'h01, 1'b0);
    wait_done("ff_01", 0);
    idle_check("ff_01");

    launch('hA5, 'h5A, 1'b1);
    wait_done("a5_5a_c1", 0);
    idle_check("a5_5a_c1");

    launch('h7F, 'h01, 1'b0);
    wait_done("7f_01", 0);
    idle_check("7f_01");

    launch('hFF, 'hFF, 1'b0);
    wait_done("ff_ff", 0);
    idle_check("ff_ff");

    launch('h10, 'h20, 1'b0);
    wait_done("ignored_start", 3);
    idle_check("ignored_start");

    // Abort mid-operation: outputs clear at once and no done appears.
    launch('h55, 'h22, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.sum", 32'(sum), 32'd0);
    check("abort.cout", 32'(cout), 32'd0);
    dummy = sb.pop_front();
    no_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) no_done = 1'b0;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("abort.no_done", 32'(no_done), 32'd1);
    last_sum  = '0;
    last_cout = 1'b0;
    launch('h03, 'h04, 1'b0);
    wait_done("after_reset", 0);
    idle_check("after_reset");

    // Start held in the done cycle chains straight into the next operation.
    launch('h40, 'h08, 1'b0);
    wait_done("b2b_first", 0);
    launch('h01, 'h02, 1'b0);
    wait_done("b2b_second", 0);
    idle_check("b2b_second");

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      launch(ra, rb, rc);
      wait_done("random", 0);
      idle_check("random");
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  operand A; sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B; sampled only on an accepted start.
REQ-007 SHALL have port cin  input  1  carry-in; sampled only on an accepted start.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result of a+b+cin, low WIDTH bits.
REQ-011 SHALL have port cout  output  1  registered carry-out of the MSB.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance load a, b into shift registers, load carry register with cin, clear bit counter, enter RUN.
REQ-014 SHALL ignore start while in RUN; operands and progress unaffected.
REQ-015 SHALL, in each RUN cycle, add LSBs of both shift registers plus carry register through one full-adder cell, shift the sum bit into the MSB of an internal result register, update the carry register from the cell's carry-out, shift both operand registers right, and increment the counter.
REQ-016 SHALL process exactly WIDTH bits; after the WIDTH-th RUN edge, enter DONE and update sum and cout from the internal result and carry registers.
REQ-017 SHALL assert done for exactly one cycle, in DONE; latency from the start-accepting edge to the edge setting done is WIDTH cycles.
REQ-018 SHALL hold busy high in RUN only; busy low in IDLE and DONE.
REQ-019 SHALL hold sum and cout at the previous result until the next completion; in-progress bits are never visible on sum.
REQ-020 SHALL return from DONE to IDLE next cycle, unless start is high in DONE, then go directly to RUN (back-to-back, no bubble).
REQ-021 SHALL keep counter width ceil(log2(WIDTH))+1; counter never wraps inside one operation.

Reset
REQ-022 SHALL, on rst_n low, immediately and asynchronously force state IDLE, busy 0, done 0, sum 0, cout 0, all internal registers 0.
REQ-023 SHALL abort an operation in progress on reset, with no done pulse; the first start after rst_n deasserts is processed normally.

Configuration
REQ-024 SHALL support macro SERIAL_ADDER_OVF_EN; when defined, add output ovf (1 bit) giving two's-complement overflow (carry into MSB XOR carry out of MSB), registered with sum, reset 0.
REQ-025 SHALL, without SERIAL_ADDER_OVF_EN, omit port ovf and its logic; all other behaviour identical.

Structure
REQ-026 SHALL place FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH constant in shared package serial_adder_pkg.
REQ-027 SHALL instantiate the existing one-bit Full_Adder (ports A, B, Cin, S, Cout) as its only sub-module for the per-bit addition.

Verification
REQ-028 SHALL cover: WIDTH=8, a=0x00, b=0x00, cin=0, start -> done exactly 8 cycles later, sum=0x00, cout=0, busy high for 8 cycles.
REQ-029 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-030 SHALL cover: with SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1, ovf=0.
REQ-031 SHALL cover: start re-pulsed with a=0x11 in RUN cycle 3 of a=0x10, b=0x20 -> ignored, sum=0x30 at done.
REQ-032 SHALL cover: rst_n low in RUN cycle 4 -> busy, done, sum, cout 0 at once, no done pulse; next start a=0x03, b=0x04 -> sum=0x07 after 8 cycles.
REQ-033 SHALL cover: start held high on the done cycle with a=0x01, b=0x02 -> RUN next cycle, second done 8 cycles later, sum=0x03.
